// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and the ALU select plus datapath/memory strobes.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
   logic [3:0] opcode;
   logic       alu_zero;
   logic       mem_ready;
   logic [2:0] alu_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       instr_done;
   logic       bus_err;
   logic       halted;

   modport master (
      input  opcode, alu_zero, mem_ready,
      output alu_sel, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
             mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
             instr_done, bus_err, halted
   );

   modport slave (
      output opcode, alu_zero, mem_ready,
      input  alu_sel, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
             mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
             instr_done, bus_err, halted
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with a memory-ready timeout.
// Build option ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of retiring as NOPs.
//
// state      | meaning
// FETCH      | read instruction at PC, PC += 4 on mem_ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// EXEC_R     | R-type ALU operation
// WB_R       | write ALUOut to rd, retire
// EXEC_BR    | compare, load PC from ALUOut if alu_zero, retire
// MEM_ADDR   | effective address = A + imm
// MEM_RD     | load data, wait for mem_ready
// WB_MEM     | write MDR to rt, retire
// MEM_WR     | store data, retire on mem_ready
// JUMP       | load PC with jump target, retire
// HALT       | trapped on illegal opcode, left only by rst
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_BR, S_MEM_ADDR,
      S_MEM_RD, S_WB_MEM, S_MEM_WR, S_JUMP, S_HALT
   } state_t;

   typedef struct packed {
      logic [2:0] alu_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       instr_done;
      logic       bus_err;
      logic       halted;
   } ctrl_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             waiting;
   logic             timeout;
   ctrl_t            c;
   ctrl_t            co;

   assign waiting = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                    && !bus.mem_ready;
   assign timeout = waiting && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // A timeout in FETCH loops back to FETCH without a state change, so it clears explicitly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  cnt <= '0;
      else if ((state_nxt != state) || timeout) cnt <= '0;
      else if (waiting)                         cnt <= cnt + CNT_W'(1);
   end

   always_comb begin
      state_nxt = state;
      c         = '0;
      case (state)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            if (bus.mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               state_nxt  = S_DECODE;
            end else if (timeout) begin
               c.bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            case (bus.opcode)
               4'b0000, 4'b0001, 4'b0010,
               4'b0011, 4'b0100, 4'b0101: state_nxt = S_EXEC_R;
               4'b0110, 4'b0111:          state_nxt = S_EXEC_BR;
               4'b1000, 4'b1001:          state_nxt = S_MEM_ADDR;
               4'b1010:                   state_nxt = S_JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_nxt = S_HALT;
`else
                  c.instr_done = 1'b1;
                  state_nxt    = S_FETCH;
`endif
               end
            endcase
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_sel   = bus.opcode[2:0];
            state_nxt   = S_WB_R;
         end
         S_WB_R: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_EXEC_BR: begin
            c.alu_src_a  = 1'b1;
            c.alu_sel    = bus.opcode[2:0];
            c.pc_src     = 2'b01;
            c.pc_write   = bus.alu_zero;
            c.instr_done = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            state_nxt   = bus.opcode[0] ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = S_WB_MEM;
            end else if (timeout) begin
               c.bus_err = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            if (bus.mem_ready) begin
               c.instr_done = 1'b1;
               state_nxt    = S_FETCH;
            end else if (timeout) begin
               c.bus_err = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_JUMP: begin
            c.pc_write   = 1'b1;
            c.pc_src     = 2'b10;
            c.instr_done = 1'b1;
            state_nxt    = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: begin
            c.halted = 1'b1;
         end
`endif
         default: state_nxt = S_FETCH;
      endcase
   end

   // Outputs are held quiet for the whole reset pulse, not just from the next edge.
   assign co = rst ? ctrl_t'(0) : c;

   assign bus.alu_sel    = co.alu_sel;
   assign bus.alu_src_a  = co.alu_src_a;
   assign bus.alu_src_b  = co.alu_src_b;
   assign bus.pc_write   = co.pc_write;
   assign bus.pc_src     = co.pc_src;
   assign bus.ir_write   = co.ir_write;
   assign bus.mem_read   = co.mem_read;
   assign bus.mem_write  = co.mem_write;
   assign bus.iord       = co.iord;
   assign bus.reg_write  = co.reg_write;
   assign bus.reg_dst    = co.reg_dst;
   assign bus.mem_to_reg = co.mem_to_reg;
   assign bus.instr_done = co.instr_done;
   assign bus.bus_err    = co.bus_err;
`ifdef ILLEGAL_TRAP_EN
   assign bus.halted     = co.halted;
`else
   assign bus.halted     = 1'b0;
`endif

endmodule
